aes_axis_out_downsizer: RTL and testbench
=========================================

Name: aes_axis_out_downsizer

Overview:
- AXI-Stream sink for the 128-bit ciphertext/keystream output of the AES-256-CTR core.
- Buffers whole blocks in a small FIFO and serializes each block into 32-bit words for a narrow downstream bus (DMA/UART/host bridge).
- Preserves tlast, and presents full-rate backpressure to the core.

Parameters:
- DATA_IN_W, 128, input block width; must be an integer multiple of DATA_OUT_W.
- DATA_OUT_W, 32, output word width.
- FIFO_DEPTH, 4, number of 128-bit blocks buffered ahead of the output stage; power of two, >=2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- s_axis_tready  out  1  block FIFO not full.
- s_axis_tvalid  in  1  input block valid.
- s_axis_tlast  in  1  last block of frame.
- s_axis_tdata  in  DATA_IN_W  input block; bits [127:96] form the first word.
- m_axis_tready  in  1  downstream ready.
- m_axis_tvalid  out  1  output word valid.
- m_axis_tlast  out  1  last word of last block of frame.
- m_axis_tdata  out  DATA_OUT_W  output word.

Behaviour:
- Reset values: s_axis_tready=0 while rst is high, 1 in the first cycle after release; m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0. FIFO pointers, count, word index and output register are all cleared.
- Ratio R = DATA_IN_W/DATA_OUT_W (4 by default). Word index idx counts 0..R-1.
- Input side:
  - Push on s_axis_tvalid && s_axis_tready. Each push stores {tlast, tdata} in the FIFO.
  - s_axis_tready = (count != FIFO_DEPTH), taken from the registered count.
  - A pop in the same cycle does not raise tready early; there is no combinational pass-through.
- Output stage states:
  - EMPTY: m_axis_tvalid=0. If the FIFO is non-empty, pop into the output register, set idx=0 and go to SEND.
  - SEND: m_axis_tvalid=1, m_axis_tdata = word idx, taken MS-first (idx0 = [127:96]). m_axis_tlast = stored_tlast && idx==R-1.
    - On handshake with idx<R-1: idx++.
    - On handshake with idx==R-1: if the FIFO is non-empty, pop the next block in the same cycle, set idx=0 and stay in SEND (no bubble). Otherwise go to EMPTY.
- Latency: a block accepted at edge E0 reaches the output register at E1; word 0 is valid after E1.
- Sustained throughput: one input block per R cycles with m_axis_tready held high.
- Simultaneous push and pop in one cycle: count is unchanged and both operations complete.
- Capacity:
  - With m_axis_tready=0, FIFO_DEPTH+1 blocks are accepted (FIFO plus output register), then s_axis_tready drops.
  - tready rises again in the cycle after the first pop.
- Stability: while m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata and m_axis_tlast hold stable.
- tlast handling: tlast=1 on an input block marks only that block's final word. tlast=0 blocks never assert m_axis_tlast.
- Reset mid-block: rst asserted at any time immediately clears all state. Any partially sent block is discarded and m_axis_tvalid falls asynchronously.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. count is log2(FIFO_DEPTH)+1 bits.

Optional Feature:
- Macro: AES_DOWNSIZER_STATS_EN.
- When defined, the block adds three outputs:
  - blocks_out [31:0]: increments on every final-word handshake.
  - frames_out [31:0]: increments on every handshake with m_axis_tlast=1.
  - max_fill [$clog2(FIFO_DEPTH):0]: high-water mark of count.
- The two counters wrap modulo 2^32. All three outputs clear on rst.
- When undefined, these ports and registers do not exist and the rest of the behaviour is identical.

Test Plan:
- Single block: push 601EC313_775789A5_B7A7F504_BBF3D228 with tlast=0 and m_axis_tready=1.
  - Required: words 601EC313, 775789A5, B7A7F504, BBF3D228 on 4 consecutive cycles, first word valid 1 cycle after the accept edge, m_axis_tlast=0 throughout.
- Frame of 4 NIST CTR ciphertext blocks (601EC313..., F443E3CA..., 2B0930DA..., DFC9C58D...) with the last block tagged tlast=1, m_axis_tready=1.
  - Required: 16 words with no gaps; m_axis_tlast=1 only on word 16 (457941A6).
- Backpressure fill: m_axis_tready=0, s_axis_tvalid held high.
  - Required: exactly 5 blocks accepted, then s_axis_tready=0.
  - m_axis_tdata stays 601EC313 (word 0 of the first block) while stalled.
  - After release, 20 words arrive in order.
- Random downstream stall (m_axis_tready toggled pseudo-randomly) with 100 sequential blocks holding counter values 0..99.
  - Required: words are reassembled and checked equal in order; no loss or duplication.
- Reset mid-block: assert rst after word 1 of a block.
  - Required: m_axis_tvalid=0 immediately.
  - After release, a new block 00112233_44556677_8899AABB_CCDDEEFF emits 00112233 as its first word.
- With AES_DOWNSIZER_STATS_EN defined, after the frame test:
  - Required: blocks_out=4, frames_out=1, max_fill>=1.
  - After the backpressure test, max_fill=4.

Source files
------------

// File: rtl/aes_axis_out_downsizer.sv
// aes_axis_out_downsizer
// Buffers whole 128-bit AES-CTR output blocks in a small FIFO and serializes
// each block into narrow words, most-significant word first. The block's tlast
// is placed on its final word only.
// Optional statistics outputs are enabled by defining AES_DOWNSIZER_STATS_EN.

module aes_axis_out_downsizer #(
    parameter int DATA_IN_W  = 128,
    parameter int DATA_OUT_W = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic [DATA_IN_W-1:0]  s_axis_tdata,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic [DATA_OUT_W-1:0] m_axis_tdata
`ifdef AES_DOWNSIZER_STATS_EN
    ,
    output logic [31:0]                   blocks_out,
    output logic [31:0]                   frames_out,
    output logic [$clog2(FIFO_DEPTH):0]   max_fill
`endif
);

    localparam int R     = DATA_IN_W / DATA_OUT_W;
    localparam int IDX_W = (R > 1) ? $clog2(R) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(R - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_SEND  = 1'b1
    } state_t;

    state_t state, state_next;

    logic [DATA_IN_W-1:0]  mem_data [FIFO_DEPTH];
    logic                  mem_last [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      idx_next;
    logic [DATA_IN_W-1:0]  out_data;
    logic                  out_last;
    logic                  push;
    logic                  pop;
    logic                  fifo_nonempty;
    logic [DATA_OUT_W-1:0] cur_word;

    // Ready depends only on the registered count, so a same-cycle pop never frees a slot early.
    assign s_axis_tready = ~rst & (count != FULL_CNT);
    assign push          = s_axis_tvalid & s_axis_tready;
    assign fifo_nonempty = (count != {CNT_W{1'b0}});

    assign m_axis_tvalid = (state == ST_SEND);
    assign m_axis_tlast  = (state == ST_SEND) & out_last & (idx == LAST_IDX);
    assign m_axis_tdata  = cur_word;

    // Select the current output word from the held block, word 0 at the top bits.
    always_comb begin
        cur_word = {DATA_OUT_W{1'b0}};
        for (int i = 0; i < R; i++) begin
            cur_word = (idx == IDX_W'(i)) ? out_data[DATA_IN_W-1-i*DATA_OUT_W -: DATA_OUT_W] : cur_word;
        end
    end

    // Output-stage next state: load a block when idle, advance words, refill with no bubble.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        pop        = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (fifo_nonempty) begin
                    pop        = 1'b1;
                    idx_next   = {IDX_W{1'b0}};
                    state_next = ST_SEND;
                end else begin
                    state_next = ST_EMPTY;
                end
            end
            ST_SEND: begin
                if (m_axis_tready) begin
                    if (idx == LAST_IDX) begin
                        if (fifo_nonempty) begin
                            pop      = 1'b1;
                            idx_next = {IDX_W{1'b0}};
                        end else begin
                            state_next = ST_EMPTY;
                        end
                    end else begin
                        idx_next = idx + IDX_W'(1);
                    end
                end else begin
                    idx_next = idx;
                end
            end
            default: begin
                state_next = ST_EMPTY;
                idx_next   = {IDX_W{1'b0}};
            end
        endcase
    end

    // Block storage; contents are qualified by the pointers, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= s_axis_tdata;
            mem_last[wr_ptr] <= s_axis_tlast;
        end
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= {PTR_W{1'b0}};
            rd_ptr <= {PTR_W{1'b0}};
            count  <= {CNT_W{1'b0}};
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Output stage state, word index and held block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_EMPTY;
            idx      <= {IDX_W{1'b0}};
            out_data <= {DATA_IN_W{1'b0}};
            out_last <= 1'b0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            if (pop) begin
                out_data <= mem_data[rd_ptr];
                out_last <= mem_last[rd_ptr];
            end
        end
    end

`ifdef AES_DOWNSIZER_STATS_EN
    // Block/frame counters (wrap naturally) and FIFO high-water mark.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blocks_out <= 32'd0;
            frames_out <= 32'd0;
            max_fill   <= {CNT_W{1'b0}};
        end else begin
            if (m_axis_tvalid && m_axis_tready && (idx == LAST_IDX)) begin
                blocks_out <= blocks_out + 32'd1;
            end
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                frames_out <= frames_out + 32'd1;
            end
            if (count > max_fill) begin
                max_fill <= count;
            end
        end
    end
`endif

endmodule

// File: tb/tb_aes_axis_out_downsizer.sv
// Self-checking bench for aes_axis_out_downsizer: a block-level queue model
// predicts every output word, tlast, valid timing and input ready; directed
// tests add hand-computed literal expectations.
`timescale 1ns/1ps

module tb_aes_axis_out_downsizer;

    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_axis_tready;
    logic         s_axis_tvalid;
    logic         s_axis_tlast;
    logic [127:0] s_axis_tdata;
    logic         m_axis_tready;
    logic         m_axis_tvalid;
    logic         m_axis_tlast;
    logic [31:0]  m_axis_tdata;
`ifdef AES_DOWNSIZER_STATS_EN
    logic [31:0]  blocks_out;
    logic [31:0]  frames_out;
    logic [2:0]   max_fill;
`endif

    aes_axis_out_downsizer #(.DATA_IN_W(128), .DATA_OUT_W(32), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tready(s_axis_tready), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tdata(s_axis_tdata),
        .m_axis_tready(m_axis_tready), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tdata(m_axis_tdata)
`ifdef AES_DOWNSIZER_STATS_EN
        , .blocks_out(blocks_out), .frames_out(frames_out), .max_fill(max_fill)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] word;
        logic        last;
        logic        fin;
        int          acc;
    } ent_t;

    ent_t q[$];
    int   nblk = 0;
    int   cyc = 0;
    int   hs_cnt = 0;
    int   tl_cnt = 0;
    logic [31:0] tl_word = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    // Compare process: predicts valid/ready/word each cycle and updates the model.
    always @(negedge clk) begin
        logic exp_v;
        logic exp_r;
        ent_t e;
        if (rst) begin
            q.delete();
            nblk = 0;
        end else begin
            exp_v = (q.size() > 0) && (q[0].acc < cyc);
            chk("m_tvalid", m_axis_tvalid, exp_v);
            exp_r = ((nblk - (exp_v ? 1 : 0)) != DEPTH);
            chk("s_tready", s_axis_tready, exp_r);
            if (exp_v && m_axis_tvalid) begin
                chk("m_tdata", m_axis_tdata, q[0].word);
                chk("m_tlast", m_axis_tlast, q[0].last);
                if (m_axis_tready) begin
                    hs_cnt++;
                    if (m_axis_tlast) begin
                        tl_cnt++;
                        tl_word = m_axis_tdata;
                    end
                    if (q[0].fin) nblk--;
                    void'(q.pop_front());
                end
            end
            if (s_axis_tvalid && s_axis_tready) begin
                for (int w = 0; w < 4; w++) begin
                    e.word = s_axis_tdata[127-32*w -: 32];
                    e.fin  = (w == 3);
                    e.last = s_axis_tlast && (w == 3);
                    e.acc  = cyc + 1;
                    q.push_back(e);
                end
                nblk++;
            end
        end
    end

    // ---------------- downstream ready driver ----------------
    logic ready_cmd = 1'b1;
    logic stall_mode = 1'b0;

    initial begin
        m_axis_tready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            m_axis_tready = stall_mode ? 1'($urandom_range(0, 1)) : ready_cmd;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [127:0] d, input logic l);
        int n;
        logic acc;
        n = 0;
        acc = 1'b0;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        while (!acc && n < 300) begin
            @(negedge clk);
            acc = s_axis_tready;
            @(posedge clk);
            n++;
        end
        #1;
        s_axis_tvalid = 1'b0;
        chk("send_accept", acc, 1'b1);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (q.size() > 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        chk("drain_done", 128'(q.size()), 128'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_s_tready", s_axis_tready, 1'b0);
        chk("rst_m_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_m_tlast", m_axis_tlast, 1'b0);
        chk("rst_m_tdata", m_axis_tdata, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [127:0] nist [4];
    logic [127:0] bp   [6];
    int h0;
    int t0;
    int k;
    logic a;

    initial begin
        nist[0] = 128'h601EC313_775789A5_B7A7F504_BBF3D228;
        nist[1] = 128'hF443E3CA_4D62B59A_CA84E990_CACAF5C5;
        nist[2] = 128'h2B0930DA_A23DE94C_E87017BA_2D84988D;
        nist[3] = 128'hDFC9C58D_B67AADA6_13C2DD08_457941A6;
        for (int i = 0; i < 4; i++) bp[i] = nist[i];
        bp[4] = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        bp[5] = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;

        rst = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = 128'd0;
        repeat (2) @(negedge clk);
        chk("rst_s_tready", s_axis_tready, 1'b0);
        chk("rst_m_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_m_tdata", m_axis_tdata, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("ready_after_release", s_axis_tready, 1'b1);

        // Single block: latency 1, four consecutive words, no tlast.
        send(nist[0], 1'b0);
        chk("single_latency_not_yet", m_axis_tvalid, 1'b0);
        @(posedge clk); #1;
        chk("single_w0_valid", m_axis_tvalid, 1'b1);
        chk("single_w0", m_axis_tdata, 32'h601EC313);
        @(posedge clk); #1;
        chk("single_w1", m_axis_tdata, 32'h775789A5);
        @(posedge clk); #1;
        chk("single_w2", m_axis_tdata, 32'hB7A7F504);
        @(posedge clk); #1;
        chk("single_w3", m_axis_tdata, 32'hBBF3D228);
        chk("single_w3_tlast", m_axis_tlast, 1'b0);
        @(posedge clk); #1;
        chk("single_idle", m_axis_tvalid, 1'b0);

        // Frame of four NIST blocks, tlast on the last one.
        do_reset();
        h0 = hs_cnt;
        t0 = tl_cnt;
        for (int i = 0; i < 4; i++) send(nist[i], i == 3);
        drain(200);
        chk("frame_words", 128'(hs_cnt - h0), 128'd16);
        chk("frame_tlast_count", 128'(tl_cnt - t0), 128'd1);
        chk("frame_tlast_word", tl_word, 32'h457941A6);
`ifdef AES_DOWNSIZER_STATS_EN
        chk("stats_blocks", blocks_out, 32'd4);
        chk("stats_frames", frames_out, 32'd1);
        chk("stats_fill_ge1", max_fill >= 3'd1, 1'b1);
`endif

        // Backpressure fill: stalled sink, tvalid held high.
        ready_cmd = 1'b0;
        @(posedge clk); #1;
        h0 = hs_cnt;
        k = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = bp[0];
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            a = s_axis_tready;
            @(posedge clk);
            if (a) k++;
            #1;
            if (k < 6) s_axis_tdata = bp[k];
        end
        s_axis_tvalid = 1'b0;
        chk("bp_accepted", 128'(k), 128'd5);
        #1;
        chk("bp_tready_low", s_axis_tready, 1'b0);
        chk("bp_hold_valid", m_axis_tvalid, 1'b1);
        chk("bp_hold_word", m_axis_tdata, 32'h601EC313);
`ifdef AES_DOWNSIZER_STATS_EN
        chk("stats_fill_4", max_fill, 3'd4);
`endif
        ready_cmd = 1'b1;
        drain(200);
        chk("bp_words", 128'(hs_cnt - h0), 128'd20);

        // Random downstream stall with 100 counter blocks.
        h0 = hs_cnt;
        stall_mode = 1'b1;
        for (int i = 0; i < 100; i++) begin
            send({32'(4*i), 32'(4*i+1), 32'(4*i+2), 32'(4*i+3)}, (i % 10) == 9);
        end
        drain(5000);
        stall_mode = 1'b0;
        chk("rand_words", 128'(hs_cnt - h0), 128'd400);

        // Reset mid-block, after word 1 has been taken.
        send(nist[1], 1'b0);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_valid_async", m_axis_tvalid, 1'b0);
        chk("midrst_tready", s_axis_tready, 1'b0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        send(bp[4], 1'b0);
        @(posedge clk); #1;
        chk("midrst_new_valid", m_axis_tvalid, 1'b1);
        chk("midrst_new_w0", m_axis_tdata, 32'h00112233);
        drain(100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
